// File: rtl/fetch_core.sv
// Instruction-fetch front end: issues word reads to a fixed-latency memory, tags returns
// with their PC, buffers them in a FIFO and hands them to decode over valid/ready.
module fetch_core #(
    parameter int                 ADDR_W       = 32,
    parameter int                 DATA_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = {ADDR_W{1'b0}},
    parameter int                 MEM_LATENCY  = 1,
    parameter int                 FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] address,
    output logic              re,
    output logic              we,
    output logic [DATA_W-1:0] data_out,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [ADDR_W-1:0]      pc_r;
    logic [ADDR_W-1:0]      address_r;
    logic                   re_r;
    logic [MEM_LATENCY-1:0] tag_vld_r, tag_vld_nxt_s;
    logic [MEM_LATENCY:0]   tag_shift_s;
    logic [ADDR_W-1:0]      tag_pc_r [MEM_LATENCY];
    logic [DATA_W-1:0]      fifo_data_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]      fifo_pc_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]       count_r, count_nxt_s;
    logic [CNT_W:0]         inflight_s;
    logic                   instr_valid_r;
    logic                   halted_r, halted_nxt_s;
    logic                   issue_s, push_s, pop_s;

    assign address     = address_r;
    assign re          = re_r;
    assign we          = 1'b0;
    assign data_out    = {DATA_W{1'b0}};
    assign instr_valid = instr_valid_r;
    assign instr_data  = fifo_data_r[rd_ptr_r];
    assign instr_pc    = fifo_pc_r[rd_ptr_r];
    assign halted      = halted_r;

    // Outstanding reads: the request on the bus now plus every valid tag in the return pipe.
    always_comb begin
        inflight_s = {{CNT_W{1'b0}}, re_r};
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_s = inflight_s + {{CNT_W{1'b0}}, tag_vld_r[i]};
        end
    end

    // Next-state, issue credit, FIFO bookkeeping and the registered halted flag.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: state_nxt_s = ST_RUN;
            ST_RUN:  state_nxt_s = halt_req ? ST_HALT : ST_RUN;
            ST_HALT: state_nxt_s = halt_req ? ST_HALT : ST_RUN;
            default: state_nxt_s = ST_BOOT;
        endcase

        // Credit uses the pre-pop count, so a freed slot is reusable only next cycle.
        issue_s = (state_r == ST_RUN) && !halt_req && !redirect_valid &&
                  (({1'b0, count_r} + inflight_s) < DEPTH_C);

        tag_shift_s = {tag_vld_r, re_r};
        if (redirect_valid) begin
            tag_vld_nxt_s = {MEM_LATENCY{1'b0}};
        end else begin
            tag_vld_nxt_s = tag_shift_s[MEM_LATENCY-1:0];
        end

        push_s = tag_vld_r[MEM_LATENCY-1] && !redirect_valid;
        pop_s  = instr_valid_r && instr_ready && !redirect_valid;

        if (redirect_valid) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end

        halted_nxt_s = (state_nxt_s == ST_HALT) && !issue_s &&
                       (tag_vld_nxt_s == {MEM_LATENCY{1'b0}}) &&
                       (count_nxt_s == {CNT_W{1'b0}});
    end

    // Control registers: FSM state, PC, memory request and status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_VECTOR;
            address_r     <= RESET_VECTOR;
            re_r          <= 1'b0;
            tag_vld_r     <= {MEM_LATENCY{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            re_r          <= issue_s;
            tag_vld_r     <= tag_vld_nxt_s;
            count_r       <= count_nxt_s;
            instr_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            halted_r      <= halted_nxt_s;
            if (redirect_valid) begin
                pc_r <= redirect_pc & ALIGN_MASK;
            end else if (issue_s) begin
                address_r <= pc_r;
                pc_r      <= pc_r + PC_STEP;
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    // PC tags ride alongside the memory latency; validity lives in tag_vld_r.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_pc_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            tag_pc_r[0] <= address_r;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_pc_r[i] <= tag_pc_r[i-1];
            end
        end
    end

    // Instruction buffer storage and pointers; redirect empties it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= {DATA_W{1'b0}};
                fifo_pc_r[i]   <= {ADDR_W{1'b0}};
            end
        end else if (redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= data_in;
                fifo_pc_r[wr_ptr_r]   <= tag_pc_r[MEM_LATENCY-1];
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_fetch_core.sv
// Directed bench for fetch_core: one instance with defaults, one with LAT=3 and a
// reset vector near the top of the address space.
module tb_fetch_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance 0: RESET_VECTOR=0, MEM_LATENCY=1, FIFO_DEPTH=4
    logic        rst0 = 1'b0, rv0 = 1'b0, halt0 = 1'b0, ir0 = 1'b0;
    logic [31:0] rpc0 = 32'h0, din0, addr0, dout0, id0, ipc0;
    logic        re0, we0, iv0, hd0;

    // Instance 1: RESET_VECTOR=FFFFFFF8, MEM_LATENCY=3, FIFO_DEPTH=4
    logic        rst1 = 1'b0, rv1 = 1'b0, halt1 = 1'b0, ir1 = 1'b0;
    logic [31:0] rpc1 = 32'h0, din1, addr1, dout1, id1, ipc1;
    logic        re1, we1, iv1, hd1;

    fetch_core #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(32'h0000_0000),
                 .MEM_LATENCY(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .resetn(rst0), .data_in(din0), .address(addr0), .re(re0), .we(we0),
        .data_out(dout0), .redirect_valid(rv0), .redirect_pc(rpc0), .halt_req(halt0),
        .instr_valid(iv0), .instr_ready(ir0), .instr_data(id0), .instr_pc(ipc0), .halted(hd0));

    fetch_core #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(32'hFFFF_FFF8),
                 .MEM_LATENCY(3), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .resetn(rst1), .data_in(din1), .address(addr1), .re(re1), .we(we1),
        .data_out(dout1), .redirect_valid(rv1), .redirect_pc(rpc1), .halt_req(halt1),
        .instr_valid(iv1), .instr_ready(ir1), .instr_data(id1), .instr_pc(ipc1), .halted(hd1));

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return ({2'b00, a[31:2]} * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // Synchronous memory models with the matching read latency
    logic [31:0] m0_q = 32'h0;
    logic [31:0] m1_q [3];
    always @(posedge clk) begin
        m0_q    <= addr0;
        m1_q[0] <= addr1;
        m1_q[1] <= m1_q[0];
        m1_q[2] <= m1_q[1];
    end
    assign din0 = mem_word(m0_q);
    assign din1 = mem_word(m1_q[2]);

    typedef struct {
        logic        ready;
        logic        exp_re;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        tv [6];
    logic [31:0] exp0, exp1, saved;
    int          pulses, pops;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at the sample point: a head that is valid with ready high pops at the next edge
    task automatic track0();
        if (iv0 && ir0) begin
            chk("u0_pop_pc", ipc0, exp0);
            chk("u0_pop_data", id0, mem_word(exp0));
            exp0 = exp0 + 32'd4;
            pops++;
        end
    endtask

    task automatic track1();
        if (iv1 && ir1) begin
            chk("u1_pop_pc", ipc1, exp1);
            chk("u1_pop_data", id1, mem_word(exp1));
            exp1 = exp1 + 32'd4;
            pops++;
        end
    endtask

    task automatic reset0();
        rst0 = 1'b0;
        step();
        step();
        #2 rst0 = 1'b1;
    endtask

    task automatic reset1();
        rst1 = 1'b0;
        step();
        step();
        #2 rst1 = 1'b1;
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_re", {31'd0, re0}, 32'd0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_valid", {31'd0, iv0}, 32'd0);
        chk("rst_halted", {31'd0, hd0}, 32'd0);
        chk("rst_we", {31'd0, we0}, 32'd0);
        chk("rst_dout", dout0, 32'h0);

        // Basic streaming, one row per edge after reset release
        tv[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        tv[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tv[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        tv[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        tv[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        tv[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        ir0 = 1'b1;
        reset0();
        for (int i = 0; i < 6; i++) begin
            ir0 = tv[i].ready;
            step();
            chk("t1_re", {31'd0, re0}, {31'd0, tv[i].exp_re});
            chk("t1_addr", addr0, tv[i].exp_addr);
            chk("t1_valid", {31'd0, iv0}, {31'd0, tv[i].exp_valid});
            if (tv[i].exp_valid) begin
                chk("t1_pc", ipc0, tv[i].exp_pc);
                chk("t1_data", id0, mem_word(tv[i].exp_pc));
            end
        end

        // Back-pressure: exactly FIFO_DEPTH requests, head held, then drain in order
        ir0 = 1'b0;
        reset0();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (re0) pulses++;
        end
        chk("t2_re_pulses", pulses, 32'd4);
        chk("t2_re_idle", {31'd0, re0}, 32'd0);
        chk("t2_valid", {31'd0, iv0}, 32'd1);
        chk("t2_head_pc", ipc0, 32'h0);
        ir0 = 1'b1;
        exp0 = 32'h0;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            track0();
            step();
        end
        chk("t2_drain_count", {31'd0, pops >= 5}, 32'd1);

        // Halt mid-stream, drain, then resume without loss or duplication
        halt0 = 1'b1;
        track0();
        step();
        chk("t5_re_after_halt", {31'd0, re0}, 32'd0);
        for (int i = 0; i < 20 && !hd0; i++) begin
            track0();
            step();
        end
        chk("t5_halted", {31'd0, hd0}, 32'd1);
        chk("t5_fifo_empty", {31'd0, iv0}, 32'd0);
        halt0 = 1'b0;
        saved = exp0;
        step();
        chk("t5_unhalted", {31'd0, hd0}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            track0();
            step();
        end
        chk("t5_resumed", {31'd0, (exp0 - saved) >= 32'd12}, 32'd1);

        // Asynchronous reset between edges while the buffer is full
        ir0 = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("t6_full_valid", {31'd0, iv0}, 32'd1);
        #3 rst0 = 1'b0;
        #1;
        chk("t6_re", {31'd0, re0}, 32'd0);
        chk("t6_addr", addr0, 32'h0);
        chk("t6_valid", {31'd0, iv0}, 32'd0);
        chk("t6_halted", {31'd0, hd0}, 32'd0);
        chk("t6_we", {31'd0, we0}, 32'd0);
        #1 rst0 = 1'b1;
        step();
        chk("t6_boot_re", {31'd0, re0}, 32'd0);
        step();
        chk("t6_restart_re", {31'd0, re0}, 32'd1);
        chk("t6_restart_addr", addr0, 32'h0);

        // PC wrap-around with latency 3
        ir1 = 1'b1;
        reset1();
        exp1 = 32'hFFFF_FFF8;
        pops = 0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            track1();
            step();
            if (re1) begin
                if (pulses == 0) chk("t4_addr0", addr1, 32'hFFFF_FFF8);
                if (pulses == 1) chk("t4_addr1", addr1, 32'hFFFF_FFFC);
                if (pulses == 2) chk("t4_addr2", addr1, 32'h0000_0000);
                pulses++;
            end
        end
        chk("t4_pop_count", {31'd0, pops >= 3}, 32'd1);

        // Redirect with two reads in flight: stale words dropped
        reset1();
        step();
        step();
        step();
        chk("t3_addr_before", addr1, 32'hFFFF_FFFC);
        rv1  = 1'b1;
        rpc1 = 32'h0000_0103;
        step();
        rv1 = 1'b0;
        chk("t3_re_after", {31'd0, re1}, 32'd0);
        chk("t3_valid_after", {31'd0, iv1}, 32'd0);
        step();
        chk("t3_new_re", {31'd0, re1}, 32'd1);
        chk("t3_new_addr", addr1, 32'h0000_0100);
        exp1 = 32'h0000_0100;
        pops = 0;
        for (int i = 0; i < 15; i++) begin
            track1();
            step();
        end
        chk("t3_pop_count", {31'd0, pops >= 2}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
